dest_track_pipe: RTL
====================

Name: dest_track_pipe

Overview:
- Carries each instruction's destination register index (rd), register-write enable (RUWr) and load flag from the DE stage through the EX, ME and WB stages.
- Produces the rd_me / rd_wb / RUWr_me / RUWr_wb operands that the forwarding unit consumes.
- Detects load-use hazards against the instruction in EX and inserts bubbles.
- Applies branch flushes and keeps saturating stall and flush counters for performance debug.

Parameters:
- REG_W, 5, width of register index.
- STALL_CNT_W, 16, width of saturating stall-cycle counter.
- FLUSH_CNT_W, 8, width of saturating flush counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset (only clock, single domain).
- rd_de  in  REG_W  destination index of instruction in DE.
- RUWr_de  in  1  DE instruction writes the register file.
- load_de  in  1  DE instruction is a load.
- valid_de  in  1  DE holds a real instruction.
- rs1_de  in  REG_W  source 1 index in DE.
- rs2_de  in  REG_W  source 2 index in DE.
- rs1_used_de  in  1  DE instruction reads rs1.
- rs2_used_de  in  1  DE instruction reads rs2.
- flush_ex  in  1  branch/jump taken in EX; DE instruction is wrong-path.
- hold_all  in  1  global freeze (memory wait); all state holds.
- rd_ex  out  REG_W  EX-stage rd.
- RUWr_ex  out  1  EX-stage effective write enable.
- rd_me  out  REG_W  ME-stage rd.
- RUWr_me  out  1  ME-stage effective write enable.
- rd_wb  out  REG_W  WB-stage rd.
- RUWr_wb  out  1  WB-stage effective write enable.
- stall_de  out  1  load-use stall request to PC and IF/DE registers.
- stall_cnt  out  STALL_CNT_W  cycles with stall_de=1.
- flush_cnt  out  FLUSH_CNT_W  cycles with flush_ex=1 and hold_all=0.

Behaviour:
- State: three stage slots, EX/ME/WB. Each slot holds {valid, rd, wr, load}.
- Outputs: RUWr_x = valid_x & wr_x for x in ex/me/wb. rd_x is the slot's stored rd.
- Capture rule: wr = RUWr_de & (rd_de != 0). An x0 destination is never reported as a write, so the forwarding unit never forwards x0.
- hazard = valid_ex & load_ex & wr_ex & ((rs1_used_de & rs1_de==rd_ex) | (rs2_used_de & rs2_de==rd_ex)).
- stall_de = hazard & valid_de & ~flush_ex. This is combinational from registered state and inputs, with zero-cycle latency.
- Each edge with rst_n=1 and hold_all=0:
  - WB <= ME; ME <= EX.
  - If flush_ex | stall_de | ~valid_de: EX <= bubble {0,0,0,0}.
  - Otherwise: EX <= {1, rd_de, wr, load_de}.
- Flush has priority over stall. Both yield a bubble; stall_de is masked so the wrong-path instruction is not held.
- hold_all=1: every slot and both counters hold. stall_de is still computed combinationally.
- A stalled load-use pair resolves in exactly one cycle. The load moves to ME, hazard drops, and the consumer enters EX on the next edge, where it forwards from ME.
- stall_cnt increments by 1 on each edge where stall_de=1 and hold_all=0. It saturates at all-ones with no wrap.
- flush_cnt increments by 1 on each edge where flush_ex=1 and hold_all=0. It saturates at all-ones.
- Reset (rst_n=0 at an edge): all slots become bubbles and both counters go to 0. All RUWr_* and rd_* outputs read 0 and stall_de=0 from the cycle after that edge.
- Reset mid-stall or mid-flush discards all in-flight state and takes priority over hold_all.
- X-free: outputs are defined whenever inputs are known.

Test Plan:
- Reset, then 3 edges with valid_de=1, rd_de=2, RUWr_de=1, load_de=0 → after edge 1: rd_ex=2, RUWr_ex=1. After edge 3: rd_wb=2, RUWr_wb=1, stall_cnt=0.
- Load rd=10 enters EX; next DE instruction has rs2_de=10, rs2_used_de=1 → stall_de=1 for exactly one cycle and EX gets a bubble (RUWr_ex=0). Next cycle: rd_me=10, RUWr_me=1, stall_de=0, stall_cnt=1.
- Same load-use setup with flush_ex=1 in that cycle → stall_de=0, EX bubble, flush_cnt=1, stall_cnt=0.
- Instruction with rd_de=0, RUWr_de=1 → RUWr_ex/me/wb stay 0 in every stage. A load to x0 with rs1_de=0 never stalls.
- hold_all=1 for 4 cycles during a pending hazard → slots unchanged, stall_de stays 1, stall_cnt unchanged. Release → one stall cycle is counted.
- Preload stall_cnt at 16'hFFFE via continuous hazards, then apply 3 more stall cycles → reads 16'hFFFF and holds. Assert rst_n=0 mid-sequence → all outputs 0 next cycle.

Source files
------------

// File: rtl/dest_track_pipe.sv
// Tracks destination register, write enable and load flag through EX/ME/WB,
// detects load-use hazards, applies flushes and keeps saturating debug counters.
module dest_track_pipe #(
    parameter int REG_W       = 5,
    parameter int STALL_CNT_W = 16,
    parameter int FLUSH_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [REG_W-1:0]       rd_de,
    input  logic                   RUWr_de,
    input  logic                   load_de,
    input  logic                   valid_de,
    input  logic [REG_W-1:0]       rs1_de,
    input  logic [REG_W-1:0]       rs2_de,
    input  logic                   rs1_used_de,
    input  logic                   rs2_used_de,
    input  logic                   flush_ex,
    input  logic                   hold_all,
    output logic [REG_W-1:0]       rd_ex,
    output logic                   RUWr_ex,
    output logic [REG_W-1:0]       rd_me,
    output logic                   RUWr_me,
    output logic [REG_W-1:0]       rd_wb,
    output logic                   RUWr_wb,
    output logic                   stall_de,
    output logic [STALL_CNT_W-1:0] stall_cnt,
    output logic [FLUSH_CNT_W-1:0] flush_cnt
);

    localparam logic [STALL_CNT_W-1:0] STALL_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [FLUSH_CNT_W-1:0] FLUSH_ONE = {{(FLUSH_CNT_W-1){1'b0}}, 1'b1};

    logic             ex_valid_q, ex_valid_d, ex_wr_q, ex_wr_d, ex_load_q, ex_load_d;
    logic             me_valid_q, me_valid_d, me_wr_q, me_wr_d, me_load_q, me_load_d;
    logic             wb_valid_q, wb_valid_d, wb_wr_q, wb_wr_d, wb_load_q, wb_load_d;
    logic [REG_W-1:0] ex_rd_q, ex_rd_d, me_rd_q, me_rd_d, wb_rd_q, wb_rd_d;

    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic hazard;
    logic wr_de;
    logic advance;

    // An x0 destination is never reported as a write, so x0 is never forwarded.
    assign wr_de   = RUWr_de & (rd_de != '0);
    assign advance = ~hold_all;

    assign hazard = ex_valid_q & ex_load_q & ex_wr_q &
                    ((rs1_used_de & (rs1_de == ex_rd_q)) |
                     (rs2_used_de & (rs2_de == ex_rd_q)));

    // Flush wins over stall: the wrong-path DE instruction must not be held.
    assign stall_de = hazard & valid_de & ~flush_ex;

    always_comb begin
        ex_valid_d  = ex_valid_q;
        ex_rd_d     = ex_rd_q;
        ex_wr_d     = ex_wr_q;
        ex_load_d   = ex_load_q;
        me_valid_d  = me_valid_q;
        me_rd_d     = me_rd_q;
        me_wr_d     = me_wr_q;
        me_load_d   = me_load_q;
        wb_valid_d  = wb_valid_q;
        wb_rd_d     = wb_rd_q;
        wb_wr_d     = wb_wr_q;
        wb_load_d   = wb_load_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (advance) begin
            wb_valid_d = me_valid_q;
            wb_rd_d    = me_rd_q;
            wb_wr_d    = me_wr_q;
            wb_load_d  = me_load_q;
            me_valid_d = ex_valid_q;
            me_rd_d    = ex_rd_q;
            me_wr_d    = ex_wr_q;
            me_load_d  = ex_load_q;

            if (flush_ex | stall_de | ~valid_de) begin
                ex_valid_d = 1'b0;
                ex_rd_d    = '0;
                ex_wr_d    = 1'b0;
                ex_load_d  = 1'b0;
            end else begin
                ex_valid_d = 1'b1;
                ex_rd_d    = rd_de;
                ex_wr_d    = wr_de;
                ex_load_d  = load_de;
            end

            if (stall_de && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + STALL_ONE;
            if (flush_ex && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + FLUSH_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid_q  <= 1'b0;
            ex_rd_q     <= '0;
            ex_wr_q     <= 1'b0;
            ex_load_q   <= 1'b0;
            me_valid_q  <= 1'b0;
            me_rd_q     <= '0;
            me_wr_q     <= 1'b0;
            me_load_q   <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_wr_q     <= 1'b0;
            wb_load_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_rd_q     <= ex_rd_d;
            ex_wr_q     <= ex_wr_d;
            ex_load_q   <= ex_load_d;
            me_valid_q  <= me_valid_d;
            me_rd_q     <= me_rd_d;
            me_wr_q     <= me_wr_d;
            me_load_q   <= me_load_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            wb_wr_q     <= wb_wr_d;
            wb_load_q   <= wb_load_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign rd_ex     = ex_rd_q;
    assign rd_me     = me_rd_q;
    assign rd_wb     = wb_rd_q;
    assign RUWr_ex   = ex_valid_q & ex_wr_q;
    assign RUWr_me   = me_valid_q & me_wr_q;
    assign RUWr_wb   = wb_valid_q & wb_wr_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

    // The load flag is only consulted in EX; later copies travel for debug visibility.
    logic unused_load;
    assign unused_load = me_load_q ^ wb_load_q;

endmodule
